control_fsm: RTL

Multi-cycle control sequencer for the 16-bit CR16-subset processor. Sits between the instruction decoder, register file, ALU, PC and the shared single-port memory. Steps each instruction through fetch, IR latch, execute, and optional memory phases, and drives every datapath enable and mux select. Also evaluates branch/jump conditions against the PSR flags.

---
 rtl/control_fsm.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CR16-subset core: steps each
// instruction through fetch/latch/execute/memory phases and drives datapath controls.
module control_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       halt,
  input  logic [7:0] op,
  input  logic       r_or_i,
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       ir_en,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       addr_sel,
  output logic       mem_we,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       flags_we,
  output logic       illegal,
  output logic [2:0] state
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned KIND_W  = 3;
  localparam int unsigned SEL_W   = 2;

  localparam logic [SEL_W-1:0] PC_INC  = 2'b00;
  localparam logic [SEL_W-1:0] PC_DISP = 2'b01;
  localparam logic [SEL_W-1:0] PC_REG  = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 3'd0,
    S_LATCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_LD_ADDR = 3'd3,
    S_LD_WB   = 3'd4,
    S_STORE   = 3'd5,
    S_BRANCH  = 3'd6
  } state_t;

  typedef enum logic [KIND_W-1:0] {
    K_ALU   = 3'd0,
    K_CMP   = 3'd1,
    K_NOP   = 3'd2,
    K_LOAD  = 3'd3,
    K_STORE = 3'd4,
    K_BCOND = 3'd5,
    K_JCOND = 3'd6,
    K_ILL   = 3'd7
  } kind_t;

  state_t     state_q;
  state_t     next_state;
  kind_t      kind;
  logic       sets_flags;
  logic       cond_true;
  logic [3:0] op_hi;
  logic [3:0] op_lo;
  logic       n_f, z_f, f_f, l_f, c_f;

  assign op_hi = op[7:4];
  assign op_lo = op[3:0];
  assign {n_f, z_f, f_f, l_f, c_f} = flags;
  assign state = state_q;

  // Opcode classification; R-type uses the low nibble, I-type only the high nibble.
  always_comb begin
    kind       = K_ILL;
    sets_flags = 1'b0;
    if (r_or_i) begin
      case (op_hi)
        4'h0: begin
          case (op_lo)
            4'h0:                     kind = K_NOP;
            4'h1, 4'h2, 4'h3, 4'hD:   kind = K_ALU;
            4'h5, 4'h9: begin
              kind       = K_ALU;
              sets_flags = 1'b1;
            end
            4'hB: begin
              kind       = K_CMP;
              sets_flags = 1'b1;
            end
            default:                  kind = K_ILL;
          endcase
        end
        4'h4: begin
          case (op_lo)
            4'h0:    kind = K_LOAD;
            4'h4:    kind = K_STORE;
            4'hC:    kind = K_JCOND;
            4'hF:    kind = K_ALU;
            default: kind = K_ILL;
          endcase
        end
        4'h8:    kind = K_ALU;
        4'hC:    kind = K_BCOND;
        default: kind = K_ILL;
      endcase
    end else begin
      case (op_hi)
        4'h1, 4'h2, 4'h3, 4'h8, 4'hD, 4'hF: kind = K_ALU;
        4'h5, 4'h9: begin
          kind       = K_ALU;
          sets_flags = 1'b1;
        end
        4'hB: begin
          kind       = K_CMP;
          sets_flags = 1'b1;
        end
        4'hC:    kind = K_BCOND;
        default: kind = K_ILL;
      endcase
    end
  end

  // Branch condition against PSR {N,Z,F,L,C}.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = z_f;
      4'h1: cond_true = ~z_f;
      4'h2: cond_true = c_f;
      4'h3: cond_true = ~c_f;
      4'h4: cond_true = l_f;
      4'h5: cond_true = ~l_f;
      4'h6: cond_true = n_f;
      4'h7: cond_true = ~n_f;
      4'h8: cond_true = f_f;
      4'h9: cond_true = ~f_f;
      4'hA: cond_true = ~l_f & ~z_f;
      4'hB: cond_true = l_f | z_f;
      4'hC: cond_true = ~n_f & ~z_f;
      4'hD: cond_true = n_f | z_f;
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= next_state;
  end

  // Next state and control outputs; everything defaults low.
  always_comb begin
    next_state = state_q;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = PC_INC;
    addr_sel   = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = 1'b0;
    flags_we   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!halt) next_state = S_LATCH;
      end
      S_LATCH: begin
        ir_en      = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        next_state = S_FETCH;
        case (kind)
          K_ALU: begin
            reg_we   = 1'b1;
            pc_en    = 1'b1;
            flags_we = sets_flags;
          end
          K_CMP: begin
            pc_en    = 1'b1;
            flags_we = 1'b1;
          end
          K_NOP:            pc_en      = 1'b1;
          K_LOAD:           next_state = S_LD_ADDR;
          K_STORE:          next_state = S_STORE;
          K_BCOND, K_JCOND: next_state = S_BRANCH;
          default: begin
            illegal = 1'b1;
            pc_en   = 1'b1;
          end
        endcase
      end
      S_LD_ADDR: begin
        addr_sel   = 1'b1;
        next_state = S_LD_WB;
      end
      // Address held through the data phase so the memory port stays stable.
      S_LD_WB: begin
        addr_sel   = 1'b1;
        wb_sel     = 1'b1;
        reg_we     = 1'b1;
        pc_en      = 1'b1;
        next_state = S_FETCH;
      end
      S_STORE: begin
        addr_sel   = 1'b1;
        mem_we     = 1'b1;
        pc_en      = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        pc_en = 1'b1;
        if (cond_true) pc_sel = (kind == K_JCOND) ? PC_REG : PC_DISP;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

endmodule
